traffic_light_monitor: RTL and testbench

//  Receive-side checker for the 4-way lamp interface {Red,Yellow,Green} per approach.

---
 rtl/traffic_pkg.sv | 47 ++++
 rtl/tl_lamp_decode.sv | 19 +
 rtl/traffic_light_monitor.sv | 194 +++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the 4-way traffic light monitor: lamp codes, approach
// indices, phase encoding (shared with the controller) and monitor FSM states.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [1:0] {
        APP_N = 2'd0,
        APP_E = 2'd1,
        APP_S = 2'd2,
        APP_W = 2'd3
    } approach_t;

    typedef enum logic [2:0] {
        PH_N_GRN = 3'd0,
        PH_N_YEL = 3'd1,
        PH_E_GRN = 3'd2,
        PH_E_YEL = 3'd3,
        PH_S_GRN = 3'd4,
        PH_S_YEL = 3'd5,
        PH_W_GRN = 3'd6,
        PH_W_YEL = 3'd7
    } phase_t;

    typedef enum logic {
        MON_SYNC  = 1'b0,
        MON_TRACK = 1'b1
    } mon_state_t;

    localparam int NUM_APPROACH = 4;

    // Phase number is the approach index with the yellow bit appended.
    function automatic logic [2:0] makePhase(input logic [1:0] approach, input logic isYel);
        return {approach, isYel};
    endfunction

    function automatic logic [2:0] nextPhase(input logic [2:0] p);
        return p + 3'd1;
    endfunction

    function automatic logic isYellowPhase(input logic [2:0] p);
        return p[0];
    endfunction

endpackage

// File: rtl/tl_lamp_decode.sv
// Combinational classifier for one approach's {R,Y,G} lamp code.
module tl_lamp_decode
    import traffic_pkg::*;
(
    input  logic [2:0] i_lamp,
    output logic       o_are_red,
    output logic       o_is_yel,
    output logic       o_is_grn,
    output logic       o_is_bad
);

    always_comb begin
        o_are_red = (i_lamp == LAMP_RED);
        o_is_yel  = (i_lamp == LAMP_YEL);
        o_is_grn  = (i_lamp == LAMP_GRN);
        o_is_bad  = !(o_are_red || o_is_yel || o_is_grn);
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the 4-way lamp interface: decodes the active phase,
// checks lamp legality, phase order and dwell times, and keeps sticky error state.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES  = 6,
    parameter int YELLOW_CYCLES = 3,
    parameter int DWELL_W       = 4,
    parameter int ERRCNT_W      = 8,
    parameter int ROTCNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          north,
    input  logic [2:0]          east,
    input  logic [2:0]          south,
    input  logic [2:0]          west,
    input  logic                clear_err,
    output logic [2:0]          phase,
    output logic                phase_valid,
    output logic                err_onehot,
    output logic                err_conflict,
    output logic                err_sequence,
    output logic                err_timing,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [ROTCNT_W-1:0] rotation_count
);

    localparam logic [DWELL_W-1:0] GREEN_LIM  = DWELL_W'(GREEN_CYCLES);
    localparam logic [DWELL_W-1:0] YELLOW_LIM = DWELL_W'(YELLOW_CYCLES);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

    mon_state_t          r_state;
    logic [2:0]          r_phase;
    logic                r_phaseValid;
    logic [DWELL_W-1:0]  r_dwell;
    logic                r_firstPhase;
    logic                r_errOnehot;
    logic                r_errConflict;
    logic                r_errSequence;
    logic                r_errTiming;
    logic [ERRCNT_W-1:0] r_errCount;
    logic [ROTCNT_W-1:0] r_rotCount;

    logic [2:0]              w_lamp [NUM_APPROACH];
    logic [NUM_APPROACH-1:0] w_red;
    logic [NUM_APPROACH-1:0] w_yel;
    logic [NUM_APPROACH-1:0] w_grn;
    logic [NUM_APPROACH-1:0] w_bad;

    assign w_lamp[APP_N] = north;
    assign w_lamp[APP_E] = east;
    assign w_lamp[APP_S] = south;
    assign w_lamp[APP_W] = west;

    for (genvar g = 0; g < NUM_APPROACH; g++) begin : g_decode
        tl_lamp_decode u_decode (
            .i_lamp    (w_lamp[g]),
            .o_are_red (w_red[g]),
            .o_is_yel  (w_yel[g]),
            .o_is_grn  (w_grn[g]),
            .o_is_bad  (w_bad[g])
        );
    end

    logic                    w_anyBad;
    logic [NUM_APPROACH-1:0] w_nonRed;
    logic                    w_legal;
    logic                    w_conflict;
    logic [1:0]              w_decApproach;
    logic [2:0]              w_decPhase;

    // Any approach that is not red must be the single active one with a Y or G code.
    always_comb begin
        w_anyBad      = |w_bad;
        w_nonRed      = ~w_red;
        w_legal       = !w_anyBad && $onehot(w_nonRed) && |(w_yel | w_grn);
        w_conflict    = !w_anyBad && !$onehot(w_nonRed);
        w_decApproach = 2'd0;
        for (int i = 0; i < NUM_APPROACH; i++) begin
            if (w_nonRed[i]) begin
                w_decApproach = 2'(i);
            end
        end
        w_decPhase = makePhase(w_decApproach, |w_yel);
    end

    logic [DWELL_W-1:0] w_curLimit;
    logic [DWELL_W-1:0] w_limitPlusOne;
    logic [DWELL_W-1:0] w_dwellInc;
    logic               w_evOnehot;
    logic               w_evConflict;
    logic               w_evSequence;
    logic               w_evTiming;
    logic               w_anyEvent;
    logic               w_rotInc;

    // Per-cycle event detection; sequence beats short-dwell, which beats rotation counting.
    always_comb begin
        w_curLimit     = isYellowPhase(r_phase) ? YELLOW_LIM : GREEN_LIM;
        w_limitPlusOne = w_curLimit + DWELL_ONE;
        w_dwellInc     = (r_dwell == '1) ? r_dwell : r_dwell + DWELL_ONE;
        w_evOnehot     = w_anyBad;
        w_evConflict   = w_conflict;
        w_evSequence   = 1'b0;
        w_evTiming     = 1'b0;
        w_rotInc       = 1'b0;
        if (r_state == MON_TRACK && w_legal) begin
            if (w_decPhase == r_phase) begin
                // The dwell != inc guard keeps a saturated counter from re-firing.
                if (w_dwellInc == w_limitPlusOne && w_dwellInc != r_dwell) begin
                    w_evTiming = 1'b1;
                end
            end else if (w_decPhase != nextPhase(r_phase)) begin
                w_evSequence = 1'b1;
            end else if (r_dwell < w_curLimit && !r_firstPhase) begin
                w_evTiming = 1'b1;
            end else if (r_phase == PH_W_YEL) begin
                w_rotInc = 1'b1;
            end
        end
        w_anyEvent = w_evOnehot || w_evConflict || w_evSequence || w_evTiming;
    end

    // Monitor FSM plus sticky flags and counters; clear_err is applied before new events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= MON_SYNC;
            r_phase       <= 3'd0;
            r_phaseValid  <= 1'b0;
            r_dwell       <= '0;
            r_firstPhase  <= 1'b1;
            r_errOnehot   <= 1'b0;
            r_errConflict <= 1'b0;
            r_errSequence <= 1'b0;
            r_errTiming   <= 1'b0;
            r_errCount    <= '0;
            r_rotCount    <= '0;
        end else begin
            r_errOnehot   <= (r_errOnehot   && !clear_err) || w_evOnehot;
            r_errConflict <= (r_errConflict && !clear_err) || w_evConflict;
            r_errSequence <= (r_errSequence && !clear_err) || w_evSequence;
            r_errTiming   <= (r_errTiming   && !clear_err) || w_evTiming;

            if (clear_err) begin
                r_errCount <= w_anyEvent ? ERRCNT_W'(1) : '0;
            end else if (w_anyEvent && r_errCount != '1) begin
                r_errCount <= r_errCount + ERRCNT_W'(1);
            end

            if (w_rotInc) begin
                r_rotCount <= r_rotCount + ROTCNT_W'(1);
            end

            case (r_state)
                MON_SYNC: begin
                    if (w_legal) begin
                        r_state      <= MON_TRACK;
                        r_phase      <= w_decPhase;
                        r_phaseValid <= 1'b1;
                        r_dwell      <= DWELL_ONE;
                        r_firstPhase <= 1'b1;
                    end
                end
                MON_TRACK: begin
                    if (!w_legal) begin
                        r_state      <= MON_SYNC;
                        r_phaseValid <= 1'b0;
                    end else if (w_decPhase == r_phase) begin
                        r_dwell <= w_dwellInc;
                    end else begin
                        r_phase      <= w_decPhase;
                        r_dwell      <= DWELL_ONE;
                        r_firstPhase <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= MON_SYNC;
                    r_phaseValid <= 1'b0;
                end
            endcase
        end
    end

    assign phase          = r_phase;
    assign phase_valid    = r_phaseValid;
    assign err_onehot     = r_errOnehot;
    assign err_conflict   = r_errConflict;
    assign err_sequence   = r_errSequence;
    assign err_timing     = r_errTiming;
    assign err_count      = r_errCount;
    assign rotation_count = r_rotCount;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a tiny controller model drives legal
// rotations, and hand-built vectors inject lamp, conflict, order and dwell faults.
module tb_traffic_light_monitor;
    import traffic_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  north = LAMP_RED;
    logic [2:0]  east  = LAMP_RED;
    logic [2:0]  south = LAMP_RED;
    logic [2:0]  west  = LAMP_RED;
    logic        clear_err = 1'b0;
    logic [2:0]  phase;
    logic        phase_valid;
    logic        err_onehot;
    logic        err_conflict;
    logic        err_sequence;
    logic        err_timing;
    logic [7:0]  err_count;
    logic [15:0] rotation_count;

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;
    int ctrlPhase = 0;
    int ctrlDwell = 0;

    traffic_light_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .north          (north),
        .east           (east),
        .south          (south),
        .west           (west),
        .clear_err      (clear_err),
        .phase          (phase),
        .phase_valid    (phase_valid),
        .err_onehot     (err_onehot),
        .err_conflict   (err_conflict),
        .err_sequence   (err_sequence),
        .err_timing     (err_timing),
        .err_count      (err_count),
        .rotation_count (rotation_count)
    );

    always #5 clk = ~clk;

    // Lamp code an approach shows while the given phase is active.
    function automatic logic [2:0] lampFor(input int p, input int approach);
        if (p / 2 != approach) return LAMP_RED;
        return (p % 2 == 1) ? LAMP_YEL : LAMP_GRN;
    endfunction

    task automatic applyStimulus(input logic [2:0] n, input logic [2:0] e,
                                 input logic [2:0] s, input logic [2:0] w,
                                 input logic clr);
        north = n;
        east = e;
        south = s;
        west = w;
        clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic runPhase(input int p, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(lampFor(p, 0), lampFor(p, 1), lampFor(p, 2), lampFor(p, 3), 1'b0);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED, 1'b0);
        applyStimulus(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED, 1'b0);
        reset = 1'b0;
        ctrlPhase = 0;
        ctrlDwell = 0;
    endtask

    // Controller model: phase 0..7 with 6-cycle greens and 3-cycle yellows.
    task automatic runController(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            runPhase(ctrlPhase, 1);
            checkOutput("ctrl_phase", 32'(phase), 32'(ctrlPhase));
            checkOutput("ctrl_valid", 32'(phase_valid), 32'd1);
            ctrlDwell++;
            if (ctrlDwell == ((ctrlPhase % 2 == 0) ? 6 : 3)) begin
                ctrlPhase = (ctrlPhase + 1) % 8;
                ctrlDwell = 0;
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_phase"}, 32'(phase), 32'd0);
        checkOutput({tag, "_valid"}, 32'(phase_valid), 32'd0);
        checkOutput({tag, "_onehot"}, 32'(err_onehot), 32'd0);
        checkOutput({tag, "_conflict"}, 32'(err_conflict), 32'd0);
        checkOutput({tag, "_sequence"}, 32'(err_sequence), 32'd0);
        checkOutput({tag, "_timing"}, 32'(err_timing), 32'd0);
        checkOutput({tag, "_errcnt"}, 32'(err_count), 32'd0);
        checkOutput({tag, "_rotcnt"}, 32'(rotation_count), 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        doReset();
        checkAllZero("reset");

        // Two full legal rotations plus a little.
        runController(80);
        checkOutput("rot_count_80", 32'(rotation_count), 32'd2);
        checkOutput("rot_onehot", 32'(err_onehot), 32'd0);
        checkOutput("rot_conflict", 32'(err_conflict), 32'd0);
        checkOutput("rot_sequence", 32'(err_sequence), 32'd0);
        checkOutput("rot_timing", 32'(err_timing), 32'd0);
        checkOutput("rot_errcnt", 32'(err_count), 32'd0);

        // Bad lamp code mid-phase, then resync without a short-dwell complaint.
        doReset();
        runPhase(0, 2);
        applyStimulus(3'b111, LAMP_RED, LAMP_RED, LAMP_RED, 1'b0);
        checkOutput("bad_onehot", 32'(err_onehot), 32'd1);
        checkOutput("bad_conflict", 32'(err_conflict), 32'd0);
        checkOutput("bad_errcnt", 32'(err_count), 32'd1);
        checkOutput("bad_valid", 32'(phase_valid), 32'd0);
        runPhase(0, 3);
        checkOutput("resync_valid", 32'(phase_valid), 32'd1);
        checkOutput("resync_phase", 32'(phase), 32'd0);
        runPhase(1, 3);
        checkOutput("resync_timing", 32'(err_timing), 32'd0);
        checkOutput("resync_sequence", 32'(err_sequence), 32'd0);
        checkOutput("resync_phase1", 32'(phase), 32'd1);
        checkOutput("resync_errcnt", 32'(err_count), 32'd1);

        // Two greens at once, then all red.
        doReset();
        runPhase(0, 1);
        applyStimulus(LAMP_GRN, LAMP_GRN, LAMP_RED, LAMP_RED, 1'b0);
        checkOutput("dual_conflict", 32'(err_conflict), 32'd1);
        checkOutput("dual_onehot", 32'(err_onehot), 32'd0);
        checkOutput("dual_errcnt", 32'(err_count), 32'd1);
        checkOutput("dual_valid", 32'(phase_valid), 32'd0);
        doReset();
        applyStimulus(LAMP_RED, LAMP_RED, LAMP_RED, LAMP_RED, 1'b0);
        checkOutput("allred_conflict", 32'(err_conflict), 32'd1);
        checkOutput("allred_errcnt", 32'(err_count), 32'd1);
        checkOutput("allred_valid", 32'(phase_valid), 32'd0);

        // Green held too long: flagged on the 7th sample, counted once.
        doReset();
        runPhase(0, 6);
        checkOutput("long_timing6", 32'(err_timing), 32'd0);
        runPhase(0, 1);
        checkOutput("long_timing7", 32'(err_timing), 32'd1);
        checkOutput("long_errcnt7", 32'(err_count), 32'd1);
        runPhase(0, 2);
        checkOutput("long_errcnt9", 32'(err_count), 32'd1);

        // Green left after only 4 cycles.
        doReset();
        runPhase(0, 6);
        runPhase(1, 3);
        runPhase(2, 4);
        checkOutput("short_before", 32'(err_timing), 32'd0);
        runPhase(3, 1);
        checkOutput("short_timing", 32'(err_timing), 32'd1);
        checkOutput("short_errcnt", 32'(err_count), 32'd1);
        checkOutput("short_sequence", 32'(err_sequence), 32'd0);
        checkOutput("short_phase", 32'(phase), 32'd3);

        // North green straight to east green skips yellow.
        doReset();
        runPhase(0, 6);
        runPhase(2, 1);
        checkOutput("skip_sequence", 32'(err_sequence), 32'd1);
        checkOutput("skip_timing", 32'(err_timing), 32'd0);
        checkOutput("skip_rotcnt", 32'(rotation_count), 32'd0);
        checkOutput("skip_phase", 32'(phase), 32'd2);
        checkOutput("skip_errcnt", 32'(err_count), 32'd1);

        // Clear coinciding with a new conflict.
        doReset();
        runPhase(0, 2);
        applyStimulus(3'b111, LAMP_RED, LAMP_RED, LAMP_RED, 1'b0);
        runPhase(0, 1);
        checkOutput("pre_clear_onehot", 32'(err_onehot), 32'd1);
        applyStimulus(LAMP_GRN, LAMP_GRN, LAMP_RED, LAMP_RED, 1'b1);
        checkOutput("clear_onehot", 32'(err_onehot), 32'd0);
        checkOutput("clear_conflict", 32'(err_conflict), 32'd1);
        checkOutput("clear_errcnt", 32'(err_count), 32'd1);

        // Reset in the middle of the second rotation.
        doReset();
        runController(44);
        checkOutput("mid_rotcnt", 32'(rotation_count), 32'd1);
        checkOutput("mid_phase", 32'(phase), 32'd1);
        reset = 1'b1;
        runPhase(ctrlPhase, 1);
        reset = 1'b0;
        checkAllZero("midreset");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
